multi_speed_ctrl: RTL and testbench
===================================

# multi_speed_ctrl

Parametrised successor to the six-axis serial speed controller. Parses ASCII hex command frames from the UART receive path into `NUM_CH` signed 8-bit channel commands plus a general-purpose output word. Applies a symmetric deadband, scales each command by its channel's maximum speed, and slew-limits the resulting target speed handed to the step generators. An optional link watchdog forces all channels to zero when frames stop arriving.

## Interface
- `NUM_CH`, 6: number of motor channels, 1..8.
- `GP_BITS`, 16: general-purpose output width, a multiple of 4, 4..32.
- `DEADBAND`, 4: deadband magnitude in command LSBs, 0..64.
- `RAMP_STEP`, 0: maximum change of `tgt_spd` per clock per channel; 0 disables ramping.
- `WDOG_CYCLES`, 50_000_000: clocks without a valid frame before timeout; used only when `MULTI_SPEED_CTRL_WDOG_EN` is defined.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `avail` in 1: `data` valid this cycle.
- `data` in 8: received ASCII byte.
- `max_spd` in 32*NUM_CH: signed max speed per channel, channel 0 in the LSBs.
- `tgt_spd` out 32*NUM_CH: signed slew-limited target speed per channel.
- `gp_out` out GP_BITS: last valid general-purpose field.
- `latched_data` out 8*NUM_CH+GP_BITS: last valid frame payload.
- `frame_ok` out 1: one-cycle pulse when a frame is latched.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `timeout` out 1: watchdog expired; held until the next valid frame. Tied to 0 when the watchdog is compiled out.

## Operation
- Frame format: `[`, then exactly NIB = 2*NUM_CH + GP_BITS/4 hex digits (`0-9`, `a-f`, `A-F`), then `]`. The first payload digit is the MSN of channel 0. `gp_out` is taken from the last GP_BITS/4 digits.
- Parser states are IDLE, PAYLOAD and CLOSE. Transitions are evaluated only on cycles where `avail` is high.
  - IDLE: `[` moves to PAYLOAD and clears the nibble count. Other bytes are ignored and produce no error.
  - PAYLOAD: a hex digit shifts into the shift register and increments the count. When the count reaches NIB-1, the state moves to CLOSE.
  - CLOSE: `]` latches the payload, pulses `frame_ok` and returns to IDLE.
  - In PAYLOAD or CLOSE, `[` restarts PAYLOAD with count 0 and produces no error. Any other byte pulses `frame_err` and returns to IDLE.
- Deadband, computed per channel: for c < -DEADBAND, mult = c + DEADBAND; for c > DEADBAND, mult = c - DEADBAND; otherwise mult = 0. c = -128 gives mult = -(128-DEADBAND).
- Scaling: cmd_spd = (max_spd × mult)[38:7], using a signed 40-bit product.
- Ramp, when RAMP_STEP > 0: each clock, `tgt_spd` moves toward cmd_spd by min(|cmd_spd - tgt_spd|, RAMP_STEP). The difference is computed in 33 bits so it never wraps. When RAMP_STEP = 0, `tgt_spd` = cmd_spd.
- `max_spd` is sampled continuously. A change propagates without a new frame.

## Timing
- Reset values are 0 for `tgt_spd`, `gp_out`, `latched_data`, `frame_ok`, `frame_err`, `timeout`, all mult registers, cmd_spd and the watchdog count. The parser resets to IDLE.
- For a `]` accepted in cycle T:
  - `latched_data`, `gp_out` and `frame_ok` update at T+1.
  - mult registers update at T+2.
  - cmd_spd updates at T+3.
  - `tgt_spd` first moves at T+4; with RAMP_STEP = 0 it equals cmd_spd at T+4.
- `frame_err` is asserted the cycle after the offending byte.
- Deasserting `rst_n` mid-frame discards the partial payload. The next frame must start with `[`.
- An aborted frame leaves every output except `frame_err` unchanged.

## Configuration
- `MULTI_SPEED_CTRL_WDOG_EN` defined: the watchdog counts clocks and reloads to 0 on each `frame_ok`.
  - When the count reaches WDOG_CYCLES-1, `timeout` rises the next cycle and all mult registers are cleared the same cycle, so targets ramp to 0.
  - `gp_out` and `latched_data` are held.
  - If `frame_ok` and expiry coincide, the frame wins: `timeout` stays 0 and the count reloads.
  - A valid frame clears `timeout` at T+1.
- Undefined: no watchdog counter, and `timeout` is tied to 0.

## Structure
- Package `multi_speed_ctrl_pkg` holds:
  - the parser state enum;
  - ASCII constants for `[` and `]`;
  - the hex-decode function;
  - the deadband function.
- Sub-module `speed_ramp` holds one channel's mult, scale and slew-limit pipeline. It is instantiated NUM_CH times in a generate loop.

## Test plan
- Frame `[7F8004FB00101234]`, defaults, all max_spd = 1280:
  - ch0 = 1230, ch1 = -1240, ch2 = 0, ch3 = -10, ch4 = 0, ch5 = 120;
  - `gp_out` = 0x1234;
  - `frame_ok` at T+1 and `tgt_spd` at T+4.
- RAMP_STEP = 100 with the ch0 frame above: ch0 reads 100, 200, … 1200, then 1230 on the 13th step and holds. Then send ch0 = 00: ch0 ramps down to 0 by 100 per clock.
- `[12G…`: `frame_err` at the cycle after `G`; outputs unchanged. A 17th hex digit instead of `]` also produces `frame_err`.
- `[12[` followed by a full valid frame: no `frame_err`; the second frame is latched.
- WDOG_EN with WDOG_CYCLES = 1000, no frames after one valid frame: `timeout` = 1 exactly 1000 clocks after `frame_ok` and targets reach 0. A new frame clears `timeout`. A frame landing on the expiry cycle keeps `timeout` = 0.
- `rst_n` low for one cycle mid-payload: all outputs 0. The remaining bytes of the old frame are ignored and produce no `frame_ok`.

Source files
------------

// File: rtl/multi_speed_ctrl_pkg.sv
// Shared types and helpers for the multi-channel serial speed controller:
// parser states, frame delimiters, hex decode and deadband shaping.
package multi_speed_ctrl_pkg;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_PAYLOAD = 2'd1,
        PS_CLOSE   = 2'd2
    } parseState_e;

    localparam logic [7:0] ASCII_LBRACK = 8'h5B;
    localparam logic [7:0] ASCII_RBRACK = 8'h5D;

    // Bit 4 flags a valid hex digit, bits 3:0 carry its value.
    function automatic logic [4:0] hexDecode(input logic [7:0] ch);
        logic [4:0] r;
        r = 5'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            r = {1'b1, 4'(ch - 8'h30)};
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            r = {1'b1, 4'(ch - 8'h57)};
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            r = {1'b1, 4'(ch - 8'h37)};
        end
        return r;
    endfunction

    function automatic logic signed [7:0] deadband(input logic signed [7:0] c, input int db);
        int ci;
        int m;
        ci = c;
        if (ci < -db) begin
            m = ci + db;
        end else if (ci > db) begin
            m = ci - db;
        end else begin
            m = 0;
        end
        return m[7:0];
    endfunction

endpackage

// File: rtl/multi_speed_ctrl_if.sv
// Receive-path byte stream from the UART into the frame parser.
interface multi_speed_ctrl_if;
    logic       avail;
    logic [7:0] data;

    modport master (output avail, output data);
    modport slave  (input avail, input data);
endinterface

// File: rtl/multi_speed_ctrl_speed_ramp.sv
// One channel: deadband register, max-speed scaling and slew-limited target.
module speed_ramp
    import multi_speed_ctrl_pkg::*;
#(
    parameter int DEADBAND  = 4,
    parameter int RAMP_STEP = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic [7:0]         cmd_i,
    input  logic signed [31:0] max_spd_i,
    output logic signed [31:0] tgt_spd_o
);
    localparam logic signed [32:0] STEP33 = 33'(RAMP_STEP);
    localparam logic signed [31:0] STEP32 = 32'(RAMP_STEP);

    logic signed [7:0]  mult_q;
    logic signed [31:0] cmd_q;
    logic signed [31:0] tgt_q;
    logic signed [31:0] tgt_d;
    logic signed [39:0] prod;
    logic signed [32:0] diff;

    assign prod = $signed({{8{max_spd_i[31]}}, max_spd_i}) * $signed({{32{mult_q[7]}}, mult_q});

    // 33-bit difference so a full-scale swing cannot wrap the step direction.
    always_comb begin
        diff  = {cmd_q[31], cmd_q} - {tgt_q[31], tgt_q};
        tgt_d = cmd_q;
        if (RAMP_STEP > 0) begin
            if (diff > STEP33) begin
                tgt_d = tgt_q + STEP32;
            end else if (diff < -STEP33) begin
                tgt_d = tgt_q - STEP32;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mult_q <= '0;
            cmd_q  <= '0;
            tgt_q  <= '0;
        end else begin
            mult_q <= clear_i ? 8'sd0 : deadband($signed(cmd_i), DEADBAND);
            cmd_q  <= 32'(prod >>> 7);
            tgt_q  <= tgt_d;
        end
    end

    assign tgt_spd_o = tgt_q;
endmodule

// File: rtl/multi_speed_ctrl.sv
// Top level: ASCII hex frame parser feeding NUM_CH speed_ramp channels.
// Optional link watchdog compiled in with MULTI_SPEED_CTRL_WDOG_EN.
module multi_speed_ctrl
    import multi_speed_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 6,
    parameter int GP_BITS     = 16,
    parameter int DEADBAND    = 4,
    parameter int RAMP_STEP   = 0,
    parameter int WDOG_CYCLES = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multi_speed_ctrl_if.slave           rx,
    input  logic [32*NUM_CH-1:0]        max_spd,
    output logic [32*NUM_CH-1:0]        tgt_spd,
    output logic [GP_BITS-1:0]          gp_out,
    output logic [8*NUM_CH+GP_BITS-1:0] latched_data,
    output logic                        frame_ok,
    output logic                        frame_err,
    output logic                        timeout
);
    localparam int NIB = 2*NUM_CH + GP_BITS/4;
    localparam int PW  = 4*NIB;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB-1);

    localparam logic [1:0] IDLE    = PS_IDLE;
    localparam logic [1:0] PAYLOAD = PS_PAYLOAD;
    localparam logic [1:0] CLOSE   = PS_CLOSE;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] nibCnt_q, nibCnt_d;
    logic [PW-1:0] shift_q, shift_d;
    logic [PW-1:0] latched_q;
    logic          frameOk_q, frameOk_d;
    logic          frameErr_q, frameErr_d;
    logic [4:0]    hex;
    logic          clearMult;

    // A '[' anywhere restarts the payload; only bytes with avail high count.
    always_comb begin
        state_d    = state_q;
        nibCnt_d   = nibCnt_q;
        shift_d    = shift_q;
        frameOk_d  = 1'b0;
        frameErr_d = 1'b0;
        hex        = hexDecode(rx.data);
        if (rx.avail) begin
            if (rx.data == ASCII_LBRACK) begin
                state_d  = PAYLOAD;
                nibCnt_d = '0;
            end else begin
                case (state_q)
                    PAYLOAD: begin
                        if (hex[4]) begin
                            shift_d = {shift_q[PW-5:0], hex[3:0]};
                            if (nibCnt_q == LAST_NIB) begin
                                state_d = CLOSE;
                            end else begin
                                nibCnt_d = nibCnt_q + CW'(1);
                            end
                        end else begin
                            state_d    = IDLE;
                            frameErr_d = 1'b1;
                        end
                    end
                    CLOSE: begin
                        state_d = IDLE;
                        if (rx.data == ASCII_RBRACK) begin
                            frameOk_d = 1'b1;
                        end else begin
                            frameErr_d = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            nibCnt_q   <= '0;
            shift_q    <= '0;
            latched_q  <= '0;
            frameOk_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nibCnt_q   <= nibCnt_d;
            shift_q    <= shift_d;
            frameOk_q  <= frameOk_d;
            frameErr_q <= frameErr_d;
            if (frameOk_d) begin
                latched_q <= shift_q;
            end
        end
    end

`ifdef MULTI_SPEED_CTRL_WDOG_EN
    localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES-1);

    logic [WW-1:0] wdog_q;
    logic          timeout_q;
    logic          expire;

    // A frame landing on the expiry cycle wins over the timeout.
    assign expire = !timeout_q && !frameOk_d && (wdog_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (frameOk_d) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (expire) begin
            timeout_q <= 1'b1;
        end else if (!timeout_q) begin
            wdog_q <= wdog_q + WW'(1);
        end
    end

    assign clearMult = expire | timeout_q;
    assign timeout   = timeout_q;
`else
    assign clearMult = 1'b0;
    assign timeout   = 1'b0;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        speed_ramp #(
            .DEADBAND  (DEADBAND),
            .RAMP_STEP (RAMP_STEP)
        ) u_ramp (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear_i   (clearMult),
            .cmd_i     (latched_q[PW-1-8*ch -: 8]),
            .max_spd_i (max_spd[32*ch +: 32]),
            .tgt_spd_o (tgt_spd[32*ch +: 32])
        );
    end

    assign latched_data = latched_q;
    assign gp_out       = latched_q[GP_BITS-1:0];
    assign frame_ok     = frameOk_q;
    assign frame_err    = frameErr_q;
endmodule

// File: tb/tb_multi_speed_ctrl.sv
// Directed bench for multi_speed_ctrl: an unramped and a ramped (step 100) instance
// share one receive stream; watchdog checks run when MULTI_SPEED_CTRL_WDOG_EN is defined.
module tb_multi_speed_ctrl;
    localparam int NUM_CH  = 6;
    localparam int GP_BITS = 16;
    localparam int PW      = 8*NUM_CH + GP_BITS;

    typedef struct {
        string       frame;
        int          maxSpd;
        int          expOk;
        int          expErr;
        int          e0, e1, e2, e3, e4, e5;
        logic [63:0] expLatched;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [32*NUM_CH-1:0] maxSpd;
    logic [32*NUM_CH-1:0] tgtA, tgtB;
    logic [GP_BITS-1:0]   gpA, gpB;
    logic [PW-1:0]        latA, latB;
    logic                 okA, okB, errA, errB, toA, toB;

    int checks = 0;
    int errors = 0;

    multi_speed_ctrl_if rxIf();

    always #5 clk = ~clk;

    multi_speed_ctrl #(
        .NUM_CH(NUM_CH), .GP_BITS(GP_BITS), .DEADBAND(4), .RAMP_STEP(0), .WDOG_CYCLES(1000)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .rx(rxIf.slave), .max_spd(maxSpd), .tgt_spd(tgtA),
        .gp_out(gpA), .latched_data(latA), .frame_ok(okA), .frame_err(errA), .timeout(toA)
    );

    multi_speed_ctrl #(
        .NUM_CH(NUM_CH), .GP_BITS(GP_BITS), .DEADBAND(4), .RAMP_STEP(100), .WDOG_CYCLES(1000)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .rx(rxIf.slave), .max_spd(maxSpd), .tgt_spd(tgtB),
        .gp_out(gpB), .latched_data(latB), .frame_ok(okB), .frame_err(errB), .timeout(toB)
    );

    task automatic checkOutput(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Streams one byte per clock from the falling edge; returns on the falling edge after the
    // last byte (frame T+1) with avail low, having counted frame_ok/frame_err pulses seen.
    task automatic applyStimulus(input string s, output int okCnt, output int errCnt);
        okCnt  = 0;
        errCnt = 0;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                okCnt  += int'(okA);
                errCnt += int'(errA);
            end
            rxIf.avail = 1'b1;
            rxIf.data  = s[i];
        end
        @(negedge clk);
        okCnt  += int'(okA);
        errCnt += int'(errA);
        rxIf.avail = 1'b0;
    endtask

    function automatic logic signed [31:0] chA(input int c);
        return $signed(tgtA[32*c +: 32]);
    endfunction

    function automatic logic signed [31:0] chB(input int c);
        return $signed(tgtB[32*c +: 32]);
    endfunction

    vec_t vecs [8];
    int   okCnt, errCnt;
    int   expArr [6];

    initial begin
        vecs[0] = '{"[7F8004FB00101234]",     1280, 1, 0, 1230, -1240, 0, -10, 0, 120, 64'h7F8004FB00101234};
        vecs[1] = '{"[12G",                   1280, 0, 1, 1230, -1240, 0, -10, 0, 120, 64'h7F8004FB00101234};
        vecs[2] = '{"zz[ff01050600fbabcd]",   1280, 1, 0, 0, 0, 10, 20, 0, -10,        64'hFF01050600FBABCD};
        vecs[3] = '{"[7F8004FB001012345",     1280, 0, 1, 0, 0, 10, 20, 0, -10,        64'hFF01050600FBABCD};
        vecs[4] = '{"[12[7F8004FB00101234]",  1280, 1, 0, 1230, -1240, 0, -10, 0, 120, 64'h7F8004FB00101234};
        vecs[5] = '{"[04FC05FB807F0000]",     1280, 1, 0, 0, 0, 10, -10, -1240, 1230,  64'h04FC05FB807F0000};
        vecs[6] = '{"[40C0000000000001]",     -256, 1, 0, -120, 120, 0, 0, 0, 0,       64'h40C0000000000001};
        vecs[7] = '{"[05FB7F80000000ff]",     100,  1, 0, 0, -1, 96, -97, 0, 0,        64'h05FB7F80000000FF};

        rxIf.avail = 1'b0;
        rxIf.data  = 8'h00;
        maxSpd     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset tgtA", {63'd0, |tgtA}, 0);
        checkOutput("reset tgtB", {63'd0, |tgtB}, 0);
        checkOutput("reset latched", latA, 0);
        checkOutput("reset gp_out", gpA, 0);
        checkOutput("reset flags", {61'd0, okA, errA, toA}, 0);
        rst_n = 1'b1;
        maxSpd = {NUM_CH{32'sd1280}};

        applyStimulus("[7F8004FB00101234]", okCnt, errCnt);
        checkOutput("ramp frame_ok at T+1", okCnt, 1);
        checkOutput("ramp gp_out at T+1", gpA, 16'h1234);
        repeat (2) @(negedge clk);
        checkOutput("tgtA still 0 at T+3", chA(0), 0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checkOutput($sformatf("ramp up ch0 step %0d", k), chB(0), (k <= 12) ? 100*k : 1230);
            if (k == 1) begin
                checkOutput("tgtA ch0 at T+4", chA(0), 1230);
                checkOutput("tgtA ch1 at T+4", chA(1), -1240);
            end
            if (k >= 12) begin
                checkOutput($sformatf("ramp up ch1 step %0d", k), chB(1), (k == 12) ? -1200 : -1240);
            end
        end
        applyStimulus("[008004FB00101234]", okCnt, errCnt);
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checkOutput($sformatf("ramp down ch0 step %0d", k), chB(0), (k <= 12) ? 1230 - 100*k : 0);
        end

        for (int v = 0; v < 8; v++) begin
            maxSpd = {NUM_CH{vecs[v].maxSpd}};
            applyStimulus(vecs[v].frame, okCnt, errCnt);
            checkOutput($sformatf("v%0d frame_ok", v), okCnt, vecs[v].expOk);
            checkOutput($sformatf("v%0d frame_err", v), errCnt, vecs[v].expErr);
            checkOutput($sformatf("v%0d latched", v), latA, vecs[v].expLatched);
            checkOutput($sformatf("v%0d gp_out", v), gpA, vecs[v].expLatched[15:0]);
            repeat (3) @(negedge clk);
            expArr = '{vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].e4, vecs[v].e5};
            for (int c = 0; c < NUM_CH; c++) begin
                checkOutput($sformatf("v%0d tgt ch%0d", v, c), chA(c), expArr[c]);
            end
            checkOutput($sformatf("v%0d timeout", v), toA, 0);
        end

        maxSpd = {NUM_CH{32'sd200}};
        repeat (3) @(negedge clk);
        checkOutput("max_spd live ch1", chA(1), -2);
        checkOutput("max_spd live ch2", chA(2), 192);
        checkOutput("max_spd live ch3", chA(3), -194);

        maxSpd = {NUM_CH{32'sd1280}};
        applyStimulus("[7F80", okCnt, errCnt);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset tgtA", {63'd0, |tgtA}, 0);
        checkOutput("midreset latched", latA, 0);
        checkOutput("midreset gp_out", gpA, 0);
        applyStimulus("04FB00101234]", okCnt, errCnt);
        checkOutput("midreset tail frame_ok", okCnt, 0);
        checkOutput("midreset tail frame_err", errCnt, 0);
        repeat (3) @(negedge clk);
        checkOutput("midreset tail latched", latA, 0);
        checkOutput("midreset tail tgtA", {63'd0, |tgtA}, 0);

`ifdef MULTI_SPEED_CTRL_WDOG_EN
        applyStimulus("[7F8004FB00101234]", okCnt, errCnt);
        repeat (999) @(negedge clk);
        checkOutput("wdog timeout before expiry", toA, 0);
        checkOutput("wdog tgt before expiry", chA(0), 1230);
        @(negedge clk);
        checkOutput("wdog timeout at 1000", toA, 1);
        repeat (2) @(negedge clk);
        checkOutput("wdog tgt ch0 zeroed", chA(0), 0);
        checkOutput("wdog tgt ch1 zeroed", chA(1), 0);
        checkOutput("wdog latched held", latA, 64'h7F8004FB00101234);
        checkOutput("wdog gp held", gpA, 16'h1234);
        applyStimulus("[7F8004FB00101234]", okCnt, errCnt);
        checkOutput("wdog cleared by frame", toA, 0);
        repeat (3) @(negedge clk);
        checkOutput("wdog tgt restored", chA(0), 1230);
        repeat (978) @(negedge clk);
        applyStimulus("[108004FB00101234]", okCnt, errCnt);
        checkOutput("wdog coincident frame_ok", okCnt, 1);
        checkOutput("wdog coincident timeout", toA, 0);
        repeat (5) @(negedge clk);
        checkOutput("wdog coincident timeout later", toA, 0);
        checkOutput("wdog coincident tgt", chA(0), 120);
`else
        repeat (20) @(negedge clk);
        checkOutput("timeout tied low", toA, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
